wb_arbiter_xbar: RTL and testbench



---
 rtl/wb_arbiter_xbar.sv | 164 ++++++++++++++++
 tb/tb_wb_arbiter_xbar.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_xbar.sv
// Wishbone shared-bus interconnect: round-robin master arbitration, base/mask
// slave decode, registered decode-error and stall-timeout error responses.
module wb_arbiter_xbar #(
    parameter int NUM_MASTERS    = 2,
    parameter int NUM_SLAVES     = 4,
    parameter int WB_DATA_WIDTH  = 32,
    parameter int WB_ADDR_WIDTH  = 32,
    parameter int WB_SEL_WIDTH   = 4,
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_BASE =
        {32'h0002_0000, 32'h0001_0100, 32'h0001_0000, 32'h0000_0000},
    parameter logic [NUM_SLAVES*WB_ADDR_WIDTH-1:0] SLAVE_MASK =
        {32'hFFFF_0000, 32'hFFFF_FF00, 32'hFFFF_FF00, 32'hFFFF_0000},
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                  clk_i,
    input  logic                                  rst_n_i,
    input  logic [NUM_MASTERS*WB_ADDR_WIDTH-1:0]  m_addr_i,
    input  logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]  m_data_i,
    input  logic [NUM_MASTERS-1:0]                m_we_i,
    input  logic [NUM_MASTERS*WB_SEL_WIDTH-1:0]   m_sel_i,
    input  logic [NUM_MASTERS-1:0]                m_stb_i,
    input  logic [NUM_MASTERS-1:0]                m_cyc_i,
    output logic [NUM_MASTERS-1:0]                m_ack_o,
    output logic [NUM_MASTERS-1:0]                m_err_o,
    output logic [NUM_MASTERS*WB_DATA_WIDTH-1:0]  m_data_o,
    output logic [WB_ADDR_WIDTH-1:0]              s_addr_o,
    output logic [WB_DATA_WIDTH-1:0]              s_data_o,
    output logic                                  s_we_o,
    output logic [WB_SEL_WIDTH-1:0]               s_sel_o,
    output logic [NUM_SLAVES-1:0]                 s_stb_o,
    output logic [NUM_SLAVES-1:0]                 s_cyc_o,
    input  logic [NUM_SLAVES-1:0]                 s_ack_i,
    input  logic [NUM_SLAVES*WB_DATA_WIDTH-1:0]   s_data_i,
    output logic [NUM_MASTERS-1:0]                grant_o,
    output logic                                  timeout_o
);
    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;
    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int AW = WB_ADDR_WIDTH;
    localparam int DW = WB_DATA_WIDTH;

    typedef enum logic [1:0] {IDLE, OWN, DRAIN} state_t;
    state_t state, state_nxt;

    logic [NUM_MASTERS-1:0] grant_q, err_q;
    logic [MW-1:0]          gidx, last_grant, pick;
    logic [CW-1:0]          cnt;
    logic                   timeout_q, derr_done;
    logic                   any_req, owning, mcyc, mstb, hit, sack;
    logic                   derr_fire, stall, to_fire;
    logic [SW-1:0]          hit_idx;

    // Rotating priority: lowest offset from last_grant+1 wins (loop runs high to low).
    always_comb begin
        any_req = |m_cyc_i;
        pick    = last_grant;
        for (int k = NUM_MASTERS; k >= 1; k--) begin
            if (m_cyc_i[(int'(last_grant) + k) % NUM_MASTERS])
                pick = MW'((int'(last_grant) + k) % NUM_MASTERS);
        end
    end

    assign s_addr_o = m_addr_i[int'(gidx)*AW +: AW];
    assign s_data_o = m_data_i[int'(gidx)*DW +: DW];
    assign s_sel_o  = m_sel_i[int'(gidx)*WB_SEL_WIDTH +: WB_SEL_WIDTH];
    assign s_we_o   = m_we_i[gidx];
    assign mcyc     = m_cyc_i[gidx];
    assign mstb     = m_stb_i[gidx];
    assign owning   = (state == OWN);

    // Lowest-numbered matching window wins on overlap.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if ((s_addr_o & SLAVE_MASK[i*AW +: AW]) == SLAVE_BASE[i*AW +: AW]) begin
                hit     = 1'b1;
                hit_idx = SW'(i);
            end
        end
    end

    assign sack = hit & s_ack_i[hit_idx];

    always_comb begin
        s_stb_o  = '0;
        s_cyc_o  = '0;
        m_ack_o  = '0;
        m_data_o = '0;
        if (owning && hit) begin
            s_cyc_o[hit_idx]             = mcyc;
            s_stb_o[hit_idx]             = mstb;
            m_ack_o[gidx]                = sack & mstb & mcyc;
            m_data_o[int'(gidx)*DW +: DW] = s_data_i[int'(hit_idx)*DW +: DW];
        end
    end

    assign derr_fire = owning && mcyc && mstb && !hit && !derr_done;
    assign stall     = owning && mcyc && mstb && hit && !sack;
    assign to_fire   = (TIMEOUT_CYCLES != 0) && stall && (cnt == CW'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any_req) state_nxt = OWN;
            OWN:     if (!mcyc) state_nxt = IDLE;
                     else if (to_fire) state_nxt = DRAIN;
            DRAIN:   if (!mcyc) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            grant_q    <= '0;
            gidx       <= '0;
            last_grant <= MW'(NUM_MASTERS - 1);
            cnt        <= '0;
            err_q      <= '0;
            timeout_q  <= 1'b0;
            derr_done  <= 1'b0;
        end else begin
            state     <= state_nxt;
            err_q     <= '0;
            timeout_q <= 1'b0;
            case (state)
                IDLE: begin
                    cnt       <= '0;
                    derr_done <= 1'b0;
                    if (any_req) begin
                        grant_q    <= NUM_MASTERS'(1) << pick;
                        gidx       <= pick;
                        last_grant <= pick;
                    end
                end
                OWN: begin
                    // Suppresses repeat errors while the same unmapped strobe is held.
                    derr_done <= mcyc && mstb && !hit;
                    if (!mcyc) begin
                        grant_q <= '0;
                        cnt     <= '0;
                    end else if (derr_fire || (sack && mstb)) begin
                        cnt <= '0;
                        if (derr_fire) err_q <= grant_q;
                    end else if (stall) begin
                        if (to_fire) begin
                            err_q     <= grant_q;
                            timeout_q <= 1'b1;
                        end
                        if (cnt != CW'(TIMEOUT_CYCLES)) cnt <= cnt + 1'b1;
                    end
                end
                DRAIN: if (!mcyc) grant_q <= '0;
                default: ;
            endcase
        end
    end

    assign grant_o   = grant_q;
    assign m_err_o   = err_q;
    assign timeout_o = timeout_q;
endmodule

// File: tb/tb_wb_arbiter_xbar.sv
// Directed self-checking bench for wb_arbiter_xbar (2 masters, 4 slaves, timeout 4).
module tb_wb_arbiter_xbar;
    localparam int NM = 2, NS = 4, DW = 32, AW = 32, SEL = 4;

    logic               clk = 1'b0, rst_n = 1'b0;
    logic [NM*AW-1:0]   m_addr;
    logic [NM*DW-1:0]   m_wdata;
    logic [NM-1:0]      m_we, m_stb, m_cyc;
    logic [NM*SEL-1:0]  m_sel;
    logic [NM-1:0]      m_ack, m_err, grant;
    logic [NM*DW-1:0]   m_rdata;
    logic [AW-1:0]      s_addr;
    logic [DW-1:0]      s_wdata;
    logic               s_we, timeout;
    logic [SEL-1:0]     s_sel;
    logic [NS-1:0]      s_stb, s_cyc, s_ack;
    logic [NS*DW-1:0]   s_rdata;
    int errors = 0, checks = 0;

    wb_arbiter_xbar #(.TIMEOUT_CYCLES(4)) dut (
        .clk_i(clk), .rst_n_i(rst_n),
        .m_addr_i(m_addr), .m_data_i(m_wdata), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_stb_i(m_stb), .m_cyc_i(m_cyc), .m_ack_o(m_ack), .m_err_o(m_err),
        .m_data_o(m_rdata), .s_addr_o(s_addr), .s_data_o(s_wdata), .s_we_o(s_we),
        .s_sel_o(s_sel), .s_stb_o(s_stb), .s_cyc_o(s_cyc), .s_ack_i(s_ack),
        .s_data_i(s_rdata), .grant_o(grant), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    task automatic drive_m(input int m, input logic cyc, input logic stb, input logic we,
                           input logic [AW-1:0] addr, input logic [DW-1:0] data);
        m_cyc[m] = cyc; m_stb[m] = stb; m_we[m] = we;
        m_addr[m*AW +: AW] = addr; m_wdata[m*DW +: DW] = data;
    endtask

    task automatic idle_all();
        m_cyc = '0; m_stb = '0; m_we = '0; s_ack = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; idle_all(); m_addr = '0; m_wdata = '0; m_sel = '1;
        s_rdata = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL reset_grant got=%b exp=00", grant); end
        checks++; if (s_stb !== 4'b0 || s_cyc !== 4'b0) begin errors++; $display("FAIL reset_slave stb=%b cyc=%b exp=0", s_stb, s_cyc); end
        checks++; if (m_err !== 2'b00 || timeout !== 1'b0 || m_ack !== 2'b00) begin errors++; $display("FAIL reset_resp err=%b to=%b ack=%b exp=0", m_err, timeout, m_ack); end
        rst_n = 1'b1;
    endtask

    task automatic test_arbitration();
        @(negedge clk);
        drive_m(0, 1, 1, 0, 32'h10, 0); drive_m(1, 1, 1, 0, 32'h10, 0); s_ack = 4'b0001;
        #1;
        checks++; if (grant !== 2'b00 || s_cyc !== 4'b0) begin errors++; $display("FAIL arb_pre grant=%b cyc=%b exp=00/0000", grant, s_cyc); end
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL arb_first got=%b exp=01", grant); end
        checks++; if (s_stb !== 4'b0001 || m_ack !== 2'b01) begin errors++; $display("FAIL arb_first_ack stb=%b ack=%b exp=0001/01", s_stb, m_ack); end
        drive_m(0, 0, 0, 0, 32'h10, 0);
        @(negedge clk);
        checks++; if (grant !== 2'b00 || m_ack !== 2'b00) begin errors++; $display("FAIL arb_idle grant=%b ack=%b exp=00/00", grant, m_ack); end
        @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL arb_second got=%b exp=10", grant); end
        checks++; if (m_ack !== 2'b10 || s_stb !== 4'b0001) begin errors++; $display("FAIL arb_second_ack ack=%b stb=%b exp=10/0001", m_ack, s_stb); end
        idle_all();
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL arb_release got=%b exp=00", grant); end
    endtask

    task automatic test_decode_read();
        drive_m(0, 1, 1, 0, 32'h0001_0104, 0);
        s_ack = 4'b0100; s_rdata[2*DW +: DW] = 32'hA5;
        @(negedge clk);
        checks++; if (grant !== 2'b01) begin errors++; $display("FAIL uart_grant got=%b exp=01", grant); end
        checks++; if (s_stb !== 4'b0100 || s_cyc !== 4'b0100) begin errors++; $display("FAIL uart_stb stb=%b cyc=%b exp=0100", s_stb, s_cyc); end
        checks++; if (m_ack !== 2'b01) begin errors++; $display("FAIL uart_ack got=%b exp=01", m_ack); end
        checks++; if (m_rdata[0 +: DW] !== 32'hA5) begin errors++; $display("FAIL uart_data got=%h exp=000000a5", m_rdata[0 +: DW]); end
        checks++; if (m_rdata[DW +: DW] !== 32'h0) begin errors++; $display("FAIL uart_data_other got=%h exp=0", m_rdata[DW +: DW]); end
        checks++; if (s_addr !== 32'h0001_0104) begin errors++; $display("FAIL uart_addr got=%h exp=00010104", s_addr); end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_decode_error();
        drive_m(1, 1, 1, 1, 32'h0003_0000, 32'hDEAD_BEEF);
        @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL derr_grant got=%b exp=10", grant); end
        checks++; if (s_stb !== 4'b0 || s_cyc !== 4'b0) begin errors++; $display("FAIL derr_nostb stb=%b cyc=%b exp=0", s_stb, s_cyc); end
        checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL derr_early got=%b exp=00", m_err); end
        checks++; if (s_we !== 1'b1 || s_wdata !== 32'hDEAD_BEEF) begin errors++; $display("FAIL derr_wbus we=%b data=%h exp=1/deadbeef", s_we, s_wdata); end
        @(negedge clk);
        checks++; if (m_err !== 2'b10) begin errors++; $display("FAIL derr_pulse got=%b exp=10", m_err); end
        @(negedge clk);
        checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL derr_single got=%b exp=00", m_err); end
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL derr_retain got=%b exp=10", grant); end
        drive_m(1, 1, 1, 1, 32'h0000_0040, 32'h1); s_ack = 4'b0001;
        #1;
        checks++; if (m_ack !== 2'b10 || s_stb !== 4'b0001) begin errors++; $display("FAIL derr_next_beat ack=%b stb=%b exp=10/0001", m_ack, s_stb); end
        @(negedge clk);
        checks++; if (m_err !== 2'b00) begin errors++; $display("FAIL derr_no_repeat got=%b exp=00", m_err); end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        drive_m(0, 1, 1, 0, 32'h20, 0); s_ack = '0;
        @(negedge clk);
        checks++; if (grant !== 2'b01 || s_cyc !== 4'b0001) begin errors++; $display("FAIL to_start grant=%b cyc=%b exp=01/0001", grant, s_cyc); end
        for (int i = 1; i <= 3; i++) begin
            @(negedge clk);
            checks++; if (timeout !== 1'b0 || m_err !== 2'b00) begin errors++; $display("FAIL to_early cycle=%0d to=%b err=%b exp=0/00", i, timeout, m_err); end
        end
        @(negedge clk);
        checks++; if (timeout !== 1'b1 || m_err !== 2'b01) begin errors++; $display("FAIL to_pulse to=%b err=%b exp=1/01", timeout, m_err); end
        checks++; if (s_cyc !== 4'b0 || s_stb !== 4'b0 || grant !== 2'b01) begin errors++; $display("FAIL to_drain cyc=%b stb=%b grant=%b exp=0/0/01", s_cyc, s_stb, grant); end
        @(negedge clk);
        checks++; if (timeout !== 1'b0 || m_err !== 2'b00) begin errors++; $display("FAIL to_single to=%b err=%b exp=0/00", timeout, m_err); end
        checks++; if (s_cyc !== 4'b0 || grant !== 2'b01) begin errors++; $display("FAIL to_hold cyc=%b grant=%b exp=0/01", s_cyc, grant); end
        idle_all();
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL to_release got=%b exp=00", grant); end
    endtask

    task automatic test_bus_lock();
        drive_m(0, 1, 1, 0, 32'h0, 0); s_ack = 4'b0001;
        @(negedge clk);
        drive_m(1, 1, 1, 0, 32'h100, 0);
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            checks++; if (grant !== 2'b01 || m_ack !== 2'b01) begin errors++; $display("FAIL lock_beat%0d grant=%b ack=%b exp=01/01", b, grant, m_ack); end
            checks++; if (s_addr !== 32'(b * 4)) begin errors++; $display("FAIL lock_addr%0d got=%h exp=%h", b, s_addr, b * 4); end
            drive_m(0, 1, 1, 0, 32'((b + 1) * 4), 0);
        end
        drive_m(0, 0, 0, 0, 32'h0, 0);
        @(negedge clk);
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL lock_idle got=%b exp=00", grant); end
        @(negedge clk);
        checks++; if (grant !== 2'b10) begin errors++; $display("FAIL lock_handover got=%b exp=10", grant); end
        idle_all();
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        drive_m(0, 1, 1, 0, 32'h4, 0);
        @(negedge clk);
        checks++; if (grant !== 2'b01 || s_stb !== 4'b0001) begin errors++; $display("FAIL rmid_pre grant=%b stb=%b exp=01/0001", grant, s_stb); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (grant !== 2'b00) begin errors++; $display("FAIL rmid_grant got=%b exp=00", grant); end
        checks++; if (s_stb !== 4'b0 || s_cyc !== 4'b0 || m_ack !== 2'b0 || m_err !== 2'b0) begin errors++; $display("FAIL rmid_bus stb=%b cyc=%b ack=%b err=%b exp=0", s_stb, s_cyc, m_ack, m_err); end
        idle_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_decode_read();
        test_decode_error();
        test_timeout();
        test_bus_lock();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
